// File: rtl/sfifo_sp_ctrl.sv
// Purpose : FIFO controller that stores words in an external single-port
//           memory and keeps a 2-entry output buffer in front of the reader.
// Latency : a word accepted at edge k with an idle read path is on o_valid/o_data
//           from edge k+2 onward (write, read, buffer push).
// Backpressure: o_ready drops when the memory is full, or when a read wins the
//           port this cycle. o_ready never looks at i_valid.
// Ports   : i_clk/i_reset_n   clock and async active-low reset
//           i_valid/i_data/o_ready   upstream write handshake
//           o_valid/o_data/i_ready   downstream read handshake
//           o_fill   entries held (memory + output buffer + in-flight read)
//           o_mem_*/i_mem_data   single-port memory; read data returns one cycle after o_mem_rd
module sfifo_sp_ctrl #(
  parameter int BW     = 48,
  parameter int LGFLEN = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_valid,
  input  logic [BW-1:0]     i_data,
  output logic              o_ready,
  output logic              o_valid,
  output logic [BW-1:0]     o_data,
  input  logic              i_ready,
  output logic [LGFLEN+1:0] o_fill,
  output logic              o_mem_wr,
  output logic [LGFLEN-1:0] o_mem_wr_addr,
  output logic [BW-1:0]     o_mem_data,
  output logic              o_mem_rd,
  output logic [LGFLEN-1:0] o_mem_rd_addr,
  input  logic [BW-1:0]     i_mem_data
);

  logic [LGFLEN-1:0] wr_ptr_q, wr_ptr_d;
  logic [LGFLEN-1:0] rd_ptr_q, rd_ptr_d;
  logic [LGFLEN:0]   mem_cnt_q, mem_cnt_d;
  logic              inflight_q, inflight_d;
  logic              prio_q, prio_d;
  logic [BW-1:0]     ob0_q, ob0_d;   // head of the output buffer
  logic [BW-1:0]     ob1_q, ob1_d;
  logic [1:0]        ob_cnt_q, ob_cnt_d;

  logic mem_full;
  logic [1:0] occ;
  logic wr_want, rd_want;
  logic wr_gnt, rd_gnt;
  logic ob_push, ob_pop;

  // mem_cnt never exceeds the depth, so its MSB alone marks full.
  assign mem_full = mem_cnt_q[LGFLEN];
  // Buffer slots already spoken for; a read in flight needs a slot on landing.
  assign occ      = ob_cnt_q + {1'b0, inflight_q};
  assign wr_want  = i_valid && !mem_full;
  assign rd_want  = (mem_cnt_q != '0) && (occ < 2'd2);

  // prio=0 favours the read, prio=1 the write; grants are held off during reset.
  assign wr_gnt = i_reset_n && wr_want && (!rd_want || prio_q);
  assign rd_gnt = i_reset_n && rd_want && (!wr_want || !prio_q);

  // Ready is computed without i_valid: it is exactly "a write would win now".
  assign o_ready = !mem_full && !(rd_want && !prio_q);

  assign o_mem_wr      = wr_gnt;
  assign o_mem_wr_addr = wr_ptr_q;
  assign o_mem_data    = i_data;
  assign o_mem_rd      = rd_gnt;
  assign o_mem_rd_addr = rd_ptr_q;

  assign o_valid = (ob_cnt_q != 2'd0);
  assign o_data  = ob0_q;
  assign o_fill  = {1'b0, mem_cnt_q}
                 + {{LGFLEN{1'b0}}, ob_cnt_q}
                 + {{(LGFLEN+1){1'b0}}, inflight_q};

  // Returned read data always lands in the buffer; the read slot check
  // guarantees there is room for it.
  assign ob_push = inflight_q;
  assign ob_pop  = o_valid && i_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_cnt_d  = mem_cnt_q;
    prio_d     = prio_q;
    // A back-to-back read keeps the flag set while the previous word lands.
    inflight_d = rd_gnt;

    if (wr_gnt) begin
      wr_ptr_d  = wr_ptr_q + LGFLEN'(1);
      mem_cnt_d = mem_cnt_q + (LGFLEN+1)'(1);
    end
    if (rd_gnt) begin
      rd_ptr_d  = rd_ptr_q + LGFLEN'(1);
      mem_cnt_d = mem_cnt_q - (LGFLEN+1)'(1);
    end
    // Toggle only on real contention so an idle side cannot steal priority.
    if (wr_want && rd_want) begin
      prio_d = !prio_q;
    end
  end

  always_comb begin
    ob0_d    = ob0_q;
    ob1_d    = ob1_q;
    ob_cnt_d = ob_cnt_q;
    case ({ob_push, ob_pop})
      2'b10: begin
        if (ob_cnt_q == 2'd0) ob0_d = i_mem_data;
        else                  ob1_d = i_mem_data;
        ob_cnt_d = ob_cnt_q + 2'd1;
      end
      2'b01: begin
        ob0_d    = ob1_q;
        ob_cnt_d = ob_cnt_q - 2'd1;
      end
      2'b11: begin
        // Count is unchanged; the new word goes behind whatever stays.
        if (ob_cnt_q == 2'd1) begin
          ob0_d = i_mem_data;
        end else begin
          ob0_d = ob1_q;
          ob1_d = i_mem_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      inflight_q <= 1'b0;
      prio_q     <= 1'b0;
      ob0_q      <= '0;
      ob1_q      <= '0;
      ob_cnt_q   <= 2'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      inflight_q <= inflight_d;
      prio_q     <= prio_d;
      ob0_q      <= ob0_d;
      ob1_q      <= ob1_d;
      ob_cnt_q   <= ob_cnt_d;
    end
  end

endmodule

// File: tb/tb_sfifo_sp_ctrl.sv
// Purpose : bench for sfifo_sp_ctrl with a behavioural single-port memory.
// Latency : inputs change 1 time unit after a rising edge, outputs are read on the falling edge.
// Backpressure: the bench drives i_ready directly to stall or drain the output.
module tb_sfifo_sp_ctrl;
  localparam int BW = 48;
  localparam int LGFLEN = 8;

  logic              i_clk = 1'b0;
  logic              i_reset_n;
  logic              i_valid;
  logic [BW-1:0]     i_data;
  logic              o_ready;
  logic              o_valid;
  logic [BW-1:0]     o_data;
  logic              i_ready;
  logic [LGFLEN+1:0] o_fill;
  logic              o_mem_wr;
  logic [LGFLEN-1:0] o_mem_wr_addr;
  logic [BW-1:0]     o_mem_data;
  logic              o_mem_rd;
  logic [LGFLEN-1:0] o_mem_rd_addr;
  logic [BW-1:0]     i_mem_data;

  sfifo_sp_ctrl #(.BW(BW), .LGFLEN(LGFLEN)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
    .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
    .o_fill(o_fill),
    .o_mem_wr(o_mem_wr), .o_mem_wr_addr(o_mem_wr_addr), .o_mem_data(o_mem_data),
    .o_mem_rd(o_mem_rd), .o_mem_rd_addr(o_mem_rd_addr), .i_mem_data(i_mem_data)
  );

  always #5 i_clk = ~i_clk;

  // Single-port memory: read data appears the cycle after the strobe.
  logic [BW-1:0] mem_model [1<<LGFLEN];
  always @(posedge i_clk) begin
    if (o_mem_wr) mem_model[o_mem_wr_addr] <= o_mem_data;
    if (o_mem_rd) i_mem_data <= mem_model[o_mem_rd_addr];
  end

  int total = 0;
  int bad = 0;
  int pops = 0;
  int proto_bad = 0;
  int word_ctr = 0;
  logic [BW-1:0] exp_q [$];
  logic [BW-1:0] sb_w;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  function automatic logic [BW-1:0] mkw(input int n);
    return {16'hC0DE, n};
  endfunction

  // Scoreboard: every accepted word must come out once, in order.
  always @(negedge i_clk) begin
    if (!i_reset_n) begin
      exp_q.delete();
    end else begin
      if (o_mem_wr && o_mem_rd) proto_bad++;
      if (o_mem_wr && (o_mem_data !== i_data)) proto_bad++;
      if (i_valid && o_ready) exp_q.push_back(i_data);
      if (o_valid && i_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got %0h want none", o_data);
        end else begin
          sb_w = exp_q.pop_front();
          chk("sb_data", 64'(o_data), 64'(sb_w));
        end
      end
    end
  end

  // Fields: vld rdy | exp wr rd | exp ordy ovld | exp fill
  typedef struct packed {
    logic vld, rdy, wr, rd, ordy, ovld;
    logic [9:0] fill;
  } vec_t;
  vec_t tbl [17];

  task automatic do_reset();
    @(posedge i_clk); #1;
    i_reset_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk); #2;
    i_reset_n = 1'b1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(posedge i_clk); #1;
      i_valid = tbl[i].vld;
      i_ready = tbl[i].rdy;
      i_data  = mkw(word_ctr);
      word_ctr++;
      @(negedge i_clk);
      chk($sformatf("row%0d", i),
          64'({o_mem_wr, o_mem_rd, o_ready, o_valid, o_fill}),
          64'({tbl[i].wr, tbl[i].rd, tbl[i].ordy, tbl[i].ovld, tbl[i].fill}));
    end
  endtask

  task automatic drain(input int budget, input string nm);
    int c = 0;
    do begin
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(negedge i_clk);
      c++;
    end while (o_fill != '0 && c < budget);
    chk({nm, "_fill0"}, 64'(o_fill), 64'd0);
    chk({nm, "_vld0"}, 64'(o_valid), 64'd0);
    chk({nm, "_rd0"}, 64'(o_mem_rd), 64'd0);
    @(posedge i_clk); #1;
    i_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int acc, cyc, p0;

    // Contention from reset, i_valid and i_ready held high.
    tbl[0]  = {6'b11_10_10, 10'd0};
    tbl[1]  = {6'b11_01_00, 10'd1};
    tbl[2]  = {6'b11_10_10, 10'd1};
    tbl[3]  = {6'b11_10_11, 10'd2};
    tbl[4]  = {6'b11_01_00, 10'd2};
    tbl[5]  = {6'b11_10_10, 10'd2};
    tbl[6]  = {6'b11_01_01, 10'd3};
    tbl[7]  = {6'b11_10_10, 10'd2};
    // Build up to o_fill=5 with a read in flight.
    tbl[8]  = {6'b10_10_10, 10'd0};
    tbl[9]  = {6'b10_01_00, 10'd1};
    tbl[10] = {6'b10_10_10, 10'd1};
    tbl[11] = {6'b10_10_11, 10'd2};
    tbl[12] = {6'b10_01_01, 10'd3};
    tbl[13] = {6'b10_10_11, 10'd3};
    tbl[14] = {6'b10_10_11, 10'd4};
    tbl[15] = {6'b11_10_11, 10'd5};
    tbl[16] = {6'b00_01_11, 10'd5};

    // Reset state, with i_valid high to show no write leaks out.
    i_reset_n = 1'b0; i_valid = 1'b1; i_ready = 1'b1; i_data = 48'h1234_5678_9ABC;
    #12;
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_fill", 64'(o_fill), 64'd0);
    chk("rst_wr", 64'(o_mem_wr), 64'd0);
    chk("rst_rd", 64'(o_mem_rd), 64'd0);
    i_valid = 1'b0; i_ready = 1'b0;
    @(negedge i_clk); #2;
    i_reset_n = 1'b1;

    // Single word: accepted at edge 0, visible from edge 2.
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_data = 48'hA5A5_0000_0001;
    @(negedge i_clk);
    chk("single_ready", 64'(o_ready), 64'd1);
    chk("single_wr_addr0", 64'({o_mem_wr, o_mem_wr_addr}), 64'h100);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("single_vld_e0", 64'(o_valid), 64'd0);
    chk("single_rd_addr0", 64'({o_mem_rd, o_mem_rd_addr}), 64'h100);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("single_vld_e1", 64'(o_valid), 64'd0);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("single_vld_e2", 64'(o_valid), 64'd1);
    chk("single_data", 64'(o_data), 64'h0000_A5A5_0000_0001);
    chk("single_fill", 64'(o_fill), 64'd1);
    drain(10, "single");

    // Read/write contention, grants must alternate.
    do_reset();
    run_rows(0, 8);
    drain(30, "cont");

    // Fill to 258 with the output stalled, then drain in order.
    do_reset();
    acc = 0; cyc = 0;
    p0 = pops;
    while (acc < 258 && cyc < 1000) begin
      @(posedge i_clk); #1;
      i_valid = 1'b1; i_ready = 1'b0; i_data = mkw(word_ctr);
      @(negedge i_clk);
      if (o_ready) begin acc++; word_ctr++; end
      cyc++;
    end
    chk("fill_accepted", 64'(acc), 64'd258);
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk); #1;
      @(negedge i_clk);
      chk("full_ready", 64'(o_ready), 64'd0);
      chk("full_no_wr", 64'(o_mem_wr), 64'd0);
      chk("full_fill", 64'(o_fill), 64'd258);
    end
    drain(600, "fill");
    chk("fill_pops", 64'(pops - p0), 64'd258);

    // Sustained traffic across pointer wrap.
    do_reset();
    acc = 0; cyc = 0;
    p0 = pops;
    while (acc < 1000 && cyc < 2100) begin
      @(posedge i_clk); #1;
      i_valid = 1'b1; i_ready = 1'b1; i_data = mkw(word_ctr);
      @(negedge i_clk);
      if (o_ready) begin acc++; word_ctr++; end
      cyc++;
    end
    chk("wrap_accepted", 64'(acc), 64'd1000);
    chk("wrap_rate", 64'(cyc <= 2008), 64'd1);
    drain(30, "wrap");
    chk("wrap_pops", 64'(pops - p0), 64'd1000);

    // Reset in the middle of traffic with a read in flight.
    do_reset();
    run_rows(8, 17);
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_ready = 1'b0;
    @(negedge i_clk);
    chk("mid_fill5", 64'(o_fill), 64'd5);
    #2 i_reset_n = 1'b0;
    #1;
    chk("mid_rst_fill", 64'(o_fill), 64'd0);
    chk("mid_rst_vld", 64'(o_valid), 64'd0);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("mid_next_fill", 64'(o_fill), 64'd0);
    chk("mid_next_vld", 64'(o_valid), 64'd0);
    #2 i_reset_n = 1'b1;
    p0 = pops;
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_data = 48'h0BAD_F00D_0042;
    @(negedge i_clk);
    chk("post_wr_addr0", 64'({o_mem_wr, o_mem_wr_addr}), 64'h100);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("post_rd_addr0", 64'({o_mem_rd, o_mem_rd_addr}), 64'h100);
    drain(20, "post");
    chk("post_pops", 64'(pops - p0), 64'd1);

    chk("mem_protocol", 64'(proto_bad), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sfifo_sp_ctrl.md
SFIFO_SP_CTRL -- requirements
Module: sfifo_sp_ctrl

Interface
REQ-001 Parameter BW, default 48, data width in bits; SHALL match the attached sfifo_mem.
REQ-002 Parameter LGFLEN, default 8, log2 of memory depth; SHALL match the attached sfifo_mem.
REQ-003 One clock; reset is asynchronous and active-low. Ports SHALL be:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_valid  in  1  upstream write request
- i_data  in  BW  upstream write data
- o_ready  out  1  write accepted this cycle when i_valid=1
- o_valid  out  1  downstream data available
- o_data  out  BW  downstream data
- i_ready  in  1  downstream consumes o_data when o_valid=1
- o_fill  out  LGFLEN+2  total entries held (memory plus output buffer)
- o_mem_wr  out  1  memory write strobe
- o_mem_wr_addr  out  LGFLEN  memory write address
- o_mem_data  out  BW  memory write data, equal to i_data
- o_mem_rd  out  1  memory read strobe
- o_mem_rd_addr  out  LGFLEN  memory read address
- i_mem_data  in  BW  memory read data, valid in the cycle after o_mem_rd

Function
REQ-004 Memory is single-port: o_mem_wr and o_mem_rd SHALL never be 1 in the same cycle.
REQ-005 State: wr_ptr and rd_ptr (LGFLEN bits each, wrap 2^LGFLEN-1 -> 0); mem_cnt (0..2^LGFLEN); 2-entry output buffer obuf (FIFO order); inflight flag; prio bit.
REQ-006 wr_want = i_valid && mem_cnt < 2^LGFLEN; rd_want = mem_cnt != 0 && (obuf occupancy + inflight) < 2.
REQ-007 If only one of wr_want/rd_want is true, that one is granted; if both, prio selects (0=read, 1=write), and prio then toggles; prio is unchanged otherwise.
REQ-008 o_ready = (mem_cnt < 2^LGFLEN) && !(rd_want && prio==0); o_ready SHALL NOT depend combinationally on i_valid.
REQ-009 Write grant: o_mem_wr=1, o_mem_wr_addr=wr_ptr; wr_ptr increments and mem_cnt increments at the edge.
REQ-010 Read grant: o_mem_rd=1, o_mem_rd_addr=rd_ptr; rd_ptr increments, mem_cnt decrements, and inflight is set at the edge.
REQ-011 When inflight=1, i_mem_data SHALL be pushed into obuf at the next edge and inflight cleared, unless a new read is granted that cycle.
REQ-012 o_valid = obuf non-empty; o_data = obuf head. A pop occurs when o_valid && i_ready. A simultaneous push and pop SHALL be legal.
REQ-013 Latency: a word accepted at edge k with an idle downstream path SHALL appear on o_valid/o_data from edge k+2 onward.
REQ-014 o_fill = mem_cnt + obuf occupancy + inflight; maximum value is 2^LGFLEN+2.
REQ-015 Output order SHALL equal acceptance order with no loss or duplication, including across pointer wrap.
REQ-016 With the memory full, o_ready=0 and i_data is not written. With o_fill=0, o_valid=0 and o_mem_rd=0.
REQ-017 Under sustained i_valid with i_ready=1, prio SHALL alternate grants so that neither reads nor writes starve.

Reset
REQ-018 On i_reset_n=0, asynchronously: pointers=0, mem_cnt=0, obuf empty, inflight=0, prio=0.
REQ-019 During reset: o_valid=0, o_fill=0, o_mem_wr=0, o_mem_rd=0. o_ready follows REQ-008 and is 1.
REQ-020 Reset asserted mid-operation SHALL discard all stored and in-flight data; any memory data returned after reset is ignored.

Verification
REQ-021 Single word: i_valid=1, i_data=0xA5A5_0000_0001 accepted at edge 0 -> o_valid=1 with that data from edge 2, o_fill=1.
REQ-022 Fill: push 258 words with i_ready=0 -> o_ready=0 after the 258th, o_fill=258, no write strobe while full; then drain -> the same 258 words in order.
REQ-023 Wrap: with i_valid and i_ready both held for 1000 words -> in-order data, throughput of at least 1 word per 2 cycles, o_mem_wr&&o_mem_rd never 1.
REQ-024 Contention: rd_want and wr_want both true for 4 cycles from reset -> grant order read, write, read, write.
REQ-025 Reset while inflight=1 and o_fill=5 -> next cycle o_fill=0 and o_valid=0; the first post-reset word is read from address 0.
